// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: register offsets, CTRL/STATUS bit positions
// and FSM state encoding shared by the SPI target files.
package spi_slave_pkg;

  localparam logic [31:0] OFF_CTRL   = 32'h0;
  localparam logic [31:0] OFF_DATA   = 32'h4;
  localparam logic [31:0] OFF_STATUS = 32'h8;

  localparam int CTRL_CPOL = 0;
  localparam int CTRL_CPHA = 1;
  localparam int CTRL_EN   = 2;

  localparam int ST_RX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_OVR      = 2;
  localparam int ST_UNR      = 3;
  localparam int ST_CS       = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: N-flop synchronizer with rise/fall pulses.
// Ports: clk, resetn, d (async pin) -> lvl, rise, fall.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: MMIO SPI target, CTRL/DATA/STATUS registers.
// Ports: mmio_* bus, spi_sck/cs_n/mosi in, miso/oe/irq out.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0070,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mmio_valid,
  input  logic        mmio_write,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic [3:0]  mmio_wstrb,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ready,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        spi_irq
);

  state_e state_q, state_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, en_q, en_d;
  logic rx_full_q, rx_full_d, tx_full_q, tx_full_d;
  logic ovr_q, ovr_d, unr_q, unr_d;
  logic [7:0] rx_data_q, rx_data_d, tx_hold_q, tx_hold_d;
  logic [7:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic miso_q, miso_d, oe_q, oe_d, irq_q, irq_d;
  logic ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic cs_active, mosi_s;
  logic sck_lead, sck_trail, sample, drive;
  logic hit_ctrl, hit_data, hit_stat;
  logic acc, ack, wr_en, rd_data, do_load;
  logic [7:0] load_byte;
  logic [31:0] status;
  logic unused_ok;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .resetn(resetn), .d(spi_sck),
    .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .resetn(resetn), .d(spi_cs_n),
    .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  assign cs_active = ~cs_lvl;
  assign mosi_s    = mosi_q[SYNC_STAGES-1];

  // After a leading edge the line sits away from its idle level.
  assign sck_lead  = (sck_rise | sck_fall) & (sck_lvl ^ cpol_q);
  assign sck_trail = (sck_rise | sck_fall) & ~(sck_lvl ^ cpol_q);
  assign sample    = cpha_q ? sck_trail : sck_lead;
  assign drive     = cpha_q ? sck_lead : sck_trail;

  assign hit_ctrl = mmio_addr == BASE_ADDR + OFF_CTRL;
  assign hit_data = mmio_addr == BASE_ADDR + OFF_DATA;
  assign hit_stat = mmio_addr == BASE_ADDR + OFF_STATUS;

  assign acc     = mmio_valid & ~ready_q;
  assign ack     = acc & ~(mmio_write & hit_data & tx_full_q);
  assign wr_en   = ack & mmio_write & mmio_wstrb[0];
  assign rd_data = ack & ~mmio_write & hit_data;

  assign load_byte = tx_full_q ? tx_hold_q : IDLE_FILL;
  assign unused_ok = ^{mmio_wdata[31:8], mmio_wstrb[3:1]};

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    en_d      = en_q;
    rx_full_d = rx_full_q;
    tx_full_d = tx_full_q;
    ovr_d     = ovr_q;
    unr_d     = unr_q;
    rx_data_d = rx_data_q;
    tx_hold_d = tx_hold_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    irq_d     = 1'b0;
    ready_d   = ack;
    rdata_d   = '0;
    do_load   = 1'b0;
    mosi_d    = {mosi_q[SYNC_STAGES-2:0], spi_mosi};

    status              = '0;
    status[ST_RX_FULL]  = rx_full_q;
    status[ST_TX_EMPTY] = ~tx_full_q;
    status[ST_OVR]      = ovr_q;
    status[ST_UNR]      = unr_q;
    status[ST_CS]       = cs_active;

    if (ack && !mmio_write) begin
      unique case (1'b1)
        hit_ctrl: rdata_d = {29'h0, en_q, cpha_q, cpol_q};
        hit_data: rdata_d = {24'h0, rx_data_q};
        hit_stat: rdata_d = status;
        default:  rdata_d = '0;
      endcase
    end

    if (rd_data) rx_full_d = 1'b0;

    if (wr_en && hit_ctrl) begin
      en_d = mmio_wdata[CTRL_EN];
      if (!cs_active) begin
        cpol_d = mmio_wdata[CTRL_CPOL];
        cpha_d = mmio_wdata[CTRL_CPHA];
      end
    end

    if (wr_en && hit_data) begin
      tx_hold_d = mmio_wdata[7:0];
      tx_full_d = 1'b1;
    end

    if (wr_en && hit_stat) begin
      if (mmio_wdata[ST_OVR]) ovr_d = 1'b0;
      if (mmio_wdata[ST_UNR]) unr_d = 1'b0;
    end

    if (state_q != S_IDLE && (cs_rise || !en_q)) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      miso_d    = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en_q && cs_fall) state_d = S_LOAD;
        end
        S_LOAD: begin
          do_load = 1'b1;
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          if (sample) begin
            rx_sr_d   = {rx_sr_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              irq_d   = 1'b1;
              do_load = 1'b1;
              // A read in the same cycle frees the slot.
              if (rx_full_q && !rd_data) begin
                ovr_d = 1'b1;
              end else begin
                rx_data_d = {rx_sr_q[6:0], mosi_s};
                rx_full_d = 1'b1;
              end
            end
          end
          // CPHA=0: MSB was put out at load time, so the
          // trailing edge right after a reload must not shift.
          if (drive && (cpha_q || bit_cnt_q != 3'd0)) begin
            miso_d  = cpha_q ? tx_sr_q[7] : tx_sr_q[6];
            tx_sr_d = tx_sr_q << 1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (do_load) begin
      tx_sr_d   = load_byte;
      bit_cnt_d = '0;
      oe_d      = 1'b1;
      if (tx_full_q) tx_full_d = 1'b0;
      else           unr_d     = 1'b1;
      if (!cpha_q)   miso_d    = load_byte[7];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      en_q      <= 1'b0;
      rx_full_q <= 1'b0;
      tx_full_q <= 1'b0;
      ovr_q     <= 1'b0;
      unr_q     <= 1'b0;
      rx_data_q <= '0;
      tx_hold_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      miso_q    <= 1'b1;
      oe_q      <= 1'b0;
      irq_q     <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      mosi_q    <= '0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      en_q      <= en_d;
      rx_full_q <= rx_full_d;
      tx_full_q <= tx_full_d;
      ovr_q     <= ovr_d;
      unr_q     <= unr_d;
      rx_data_q <= rx_data_d;
      tx_hold_q <= tx_hold_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      irq_q     <= irq_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      mosi_q    <= mosi_d;
    end
  end

  assign mmio_rdata  = rdata_q;
  assign mmio_ready  = ready_q;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign spi_irq     = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: SPI master + MMIO driver around spi_slave,
// checked against a byte-level model of the register file.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0070;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic resetn;
  logic mmio_valid, mmio_write;
  logic [31:0] mmio_addr, mmio_wdata;
  logic [3:0] mmio_wstrb;
  logic [31:0] mmio_rdata;
  logic mmio_ready;
  logic sck, cs_n, mosi;
  logic miso, miso_oe, irq;

  int n_run = 0;
  int n_fail = 0;
  int irq_cnt = 0;

  logic [7:0] m_txq[$];
  logic m_rx_full, m_ovr, m_unr;
  logic [7:0] m_rx_data;

  spi_slave dut (
    .clk(clk), .resetn(resetn),
    .mmio_valid(mmio_valid), .mmio_write(mmio_write),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_wstrb(mmio_wstrb), .mmio_rdata(mmio_rdata),
    .mmio_ready(mmio_ready),
    .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso), .spi_miso_oe(miso_oe), .spi_irq(irq)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (irq) irq_cnt <= irq_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_txq.delete();
    m_rx_full = 0; m_ovr = 0; m_unr = 0; m_rx_data = 0;
  endtask

  task automatic model_load(output logic [7:0] b);
    if (m_txq.size() > 0) b = m_txq.pop_front();
    else begin b = 8'hFF; m_unr = 1; end
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (m_rx_full) m_ovr = 1;
    else begin m_rx_data = b; m_rx_full = 1; end
  endtask

  function automatic logic [31:0] model_status();
    return {27'h0, 1'b0, m_unr, m_ovr,
            m_txq.size() == 0, m_rx_full};
  endfunction

  task automatic mmio_wr(input logic [31:0] off,
                         input logic [31:0] d,
                         input int lim, output bit acked);
    @(negedge clk);
    mmio_valid = 1; mmio_write = 1;
    mmio_addr = BASE + off; mmio_wdata = d;
    mmio_wstrb = 4'h1; acked = 0;
    for (int i = 0; i < lim && !acked; i++) begin
      @(negedge clk);
      if (mmio_ready) acked = 1;
    end
    mmio_valid = 0; mmio_write = 0;
  endtask

  task automatic mmio_rd(input logic [31:0] off,
                         output logic [31:0] d);
    bit got;
    @(negedge clk);
    mmio_valid = 1; mmio_write = 0;
    mmio_addr = BASE + off; got = 0; d = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mmio_ready) begin got = 1; d = mmio_rdata; end
    end
    mmio_valid = 0;
    if (!got) begin
      n_run++; n_fail++;
      $display("FAIL rd_timeout: off %h no ready, need ack", off);
    end
  endtask

  task automatic wr_data(input logic [7:0] b, output bit ok);
    mmio_wr(OFF_DATA, {24'h0, b}, 10, ok);
    if (ok) m_txq.push_back(b);
  endtask

  task automatic wr_ctrl(input logic [1:0] m);
    bit ok;
    mmio_wr(OFF_CTRL, {29'h0, 1'b1, m[0], m[1]}, 10, ok);
  endtask

  task automatic w1c(input logic [31:0] v);
    bit ok;
    mmio_wr(OFF_STATUS, v, 10, ok);
    if (ok && v[2]) m_ovr = 0;
    if (ok && v[3]) m_unr = 0;
  endtask

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_start(input logic cpol);
    @(negedge clk);
    sck = cpol;
    repeat (8) @(negedge clk);
    cs_n = 0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    half_wait();
    cs_n = 1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [1:0] m,
                          input logic [7:0] mo,
                          input int nbits,
                          output logic [7:0] mi);
    mi = 0;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        mosi = mo[7-i];
        half_wait();
        mi = {mi[6:0], miso};
        sck = ~sck;
        half_wait();
        sck = ~sck;
      end else begin
        half_wait();
        sck = ~sck;
        mosi = mo[7-i];
        half_wait();
        mi = {mi[6:0], miso};
        sck = ~sck;
      end
    end
  endtask

  task automatic frame1(input logic [1:0] m,
                        input logic [7:0] mo,
                        output logic [7:0] mi,
                        output logic [7:0] emi);
    logic [7:0] nx;
    cs_start(m[1]);
    model_load(emi);
    spi_byte(m, mo, 8, mi);
    model_rx(mo);
    model_load(nx);
    cs_end();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    resetn = 0; sck = 0; cs_n = 1; mosi = 0;
    mmio_valid = 0; mmio_write = 0; mmio_addr = 0;
    mmio_wdata = 0; mmio_wstrb = 0;
    model_reset();
    repeat (5) @(negedge clk);
    n_run++;
    if ({miso, miso_oe, irq, mmio_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_pins: got %b need 1000",
               {miso, miso_oe, irq, mmio_ready});
    end
    n_run++;
    if (mmio_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdata: got %h need 0", mmio_rdata);
    end
    resetn = 1;
    repeat (2) @(negedge clk);
    mmio_valid = 1; mmio_write = 0;
    mmio_addr = BASE + OFF_STATUS;
    @(negedge clk);
    n_run++;
    if (mmio_ready !== 1'b1 || mmio_rdata !== 32'h2) begin
      n_fail++;
      $display("FAIL rst_status: rdy %b data %h need 1 00000002",
               mmio_ready, mmio_rdata);
    end
    @(negedge clk);
    n_run++;
    if (mmio_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_b2b: got %b need 0", mmio_ready);
    end
    mmio_valid = 0;
    mmio_rd(OFF_CTRL, d);
    n_run++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_ctrl: got %h need 0", d);
    end
    mmio_rd(32'hC, d);
    n_run++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped: got %h need 0", d);
    end
  endtask

  task automatic test_mode0();
    logic [7:0] mi, emi, nx;
    logic [31:0] d, e;
    bit ok;
    int i0;
    wr_ctrl(2'b00);
    wr_data(8'hA5, ok);
    i0 = irq_cnt;
    cs_start(1'b0);
    model_load(emi);
    n_run++;
    if (miso_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL m0_oe: got %b need 1", miso_oe);
    end
    spi_byte(2'b00, 8'h3C, 8, mi);
    model_rx(8'h3C);
    model_load(nx);
    cs_end();
    n_run++;
    if (mi !== 8'hA5) begin
      n_fail++;
      $display("FAIL m0_miso: got %h need a5", mi);
    end
    n_run++;
    if (irq_cnt - i0 !== 1) begin
      n_fail++;
      $display("FAIL m0_irq: got %0d need 1", irq_cnt - i0);
    end
    mmio_rd(OFF_STATUS, d);
    n_run++;
    if (d !== model_status()) begin
      n_fail++;
      $display("FAIL m0_status: got %h need %h", d, model_status());
    end
    mmio_rd(OFF_DATA, d);
    e = {24'h0, m_rx_data}; m_rx_full = 0;
    n_run++;
    if (d !== e || e !== 32'h3C) begin
      n_fail++;
      $display("FAIL m0_data: got %h need 0000003c", d);
    end
    n_run++;
    if (miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL m0_oe_off: got %b need 0", miso_oe);
    end
  endtask

  task automatic test_modes();
    logic [1:0] m;
    logic [7:0] tx, rx, mi, emi;
    logic [31:0] d, e;
    bit ok;
    int i0;
    for (int k = 0; k < 9; k++) begin
      if (k < 3) begin
        m = 2'(k + 1); tx = 8'h81; rx = 8'h7E;
      end else begin
        m = 2'($urandom_range(0, 3));
        tx = 8'($urandom); rx = 8'($urandom);
      end
      wr_ctrl(m);
      wr_data(tx, ok);
      i0 = irq_cnt;
      frame1(m, rx, mi, emi);
      n_run++;
      if (mi !== emi || emi !== tx) begin
        n_fail++;
        $display("FAIL mode%0d_miso: got %h need %h", m, mi, tx);
      end
      mmio_rd(OFF_DATA, d);
      e = {24'h0, m_rx_data}; m_rx_full = 0;
      n_run++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL mode%0d_data: got %h need %h", m, d, e);
      end
      n_run++;
      if (irq_cnt - i0 !== 1) begin
        n_fail++;
        $display("FAIL mode%0d_irq: got %0d need 1", m, irq_cnt - i0);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] r[3];
    logic [7:0] e[4];
    logic [7:0] mi;
    logic [31:0] d, ed;
    bit ok;
    int i0;
    w1c(32'hC);
    wr_ctrl(2'b00);
    for (int k = 0; k < 3; k++) r[k] = 8'($urandom);
    wr_data(8'($urandom), ok);
    i0 = irq_cnt;
    cs_start(1'b0);
    model_load(e[0]);
    wr_data(8'($urandom), ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL burst_wr: got no ack need ack");
    end
    for (int k = 0; k < 3; k++) begin
      spi_byte(2'b00, r[k], 8, mi);
      model_rx(r[k]);
      model_load(e[k+1]);
      n_run++;
      if (mi !== e[k]) begin
        n_fail++;
        $display("FAIL burst_miso%0d: got %h need %h", k, mi, e[k]);
      end
    end
    cs_end();
    n_run++;
    if (e[2] !== 8'hFF) begin
      n_fail++;
      $display("FAIL burst_fill: got %h need ff", e[2]);
    end
    mmio_rd(OFF_STATUS, d);
    n_run++;
    if (d !== model_status()) begin
      n_fail++;
      $display("FAIL burst_status: got %h need %h", d, model_status());
    end
    mmio_rd(OFF_DATA, d);
    ed = {24'h0, m_rx_data}; m_rx_full = 0;
    n_run++;
    if (d !== ed || d !== {24'h0, r[0]}) begin
      n_fail++;
      $display("FAIL burst_data: got %h need %h", d, r[0]);
    end
    n_run++;
    if (irq_cnt - i0 !== 3) begin
      n_fail++;
      $display("FAIL burst_irq: got %0d need 3", irq_cnt - i0);
    end
  endtask

  task automatic test_abort();
    logic [1:0] m;
    logic [7:0] mi, emi, dm;
    logic [31:0] d, e;
    bit ok;
    int i0;
    m = 2'($urandom_range(0, 3));
    w1c(32'hC);
    wr_ctrl(m);
    i0 = irq_cnt;
    cs_start(m[1]);
    model_load(dm);
    spi_byte(m, 8'($urandom), 4, mi);
    cs_end();
    n_run++;
    if (irq_cnt - i0 !== 0) begin
      n_fail++;
      $display("FAIL abort_irq: got %0d need 0", irq_cnt - i0);
    end
    mmio_rd(OFF_STATUS, d);
    n_run++;
    if (d !== model_status()) begin
      n_fail++;
      $display("FAIL abort_status: got %h need %h", d, model_status());
    end
    wr_data(8'h55, ok);
    i0 = irq_cnt;
    frame1(m, 8'h55, mi, emi);
    n_run++;
    if (mi !== emi) begin
      n_fail++;
      $display("FAIL abort_miso: got %h need %h", mi, emi);
    end
    mmio_rd(OFF_DATA, d);
    e = {24'h0, m_rx_data}; m_rx_full = 0;
    n_run++;
    if (d !== e || d !== 32'h55) begin
      n_fail++;
      $display("FAIL abort_data: got %h need 00000055", d);
    end
    n_run++;
    if (irq_cnt - i0 !== 1) begin
      n_fail++;
      $display("FAIL abort_irq2: got %0d need 1", irq_cnt - i0);
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] mi, emi;
    logic [31:0] d;
    bit ok;
    w1c(32'hC);
    wr_ctrl(2'b00);
    wr_data(8'h11, ok);
    mmio_wr(OFF_DATA, 32'h22, 20, ok);
    n_run++;
    if (ok) begin
      n_fail++;
      $display("FAIL txfull_noack: got ack need none in 20 cycles");
    end
    frame1(2'b00, 8'($urandom), mi, emi);
    n_run++;
    if (mi !== 8'h11 || emi !== 8'h11) begin
      n_fail++;
      $display("FAIL txfull_miso: got %h need 11", mi);
    end
    wr_data(8'h22, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL txfull_retry: got no ack need ack");
    end
    frame1(2'b00, 8'($urandom), mi, emi);
    n_run++;
    if (mi !== 8'h22) begin
      n_fail++;
      $display("FAIL txfull_miso2: got %h need 22", mi);
    end
    mmio_rd(OFF_STATUS, d);
    n_run++;
    if (d !== model_status() || d[3:2] !== 2'b11) begin
      n_fail++;
      $display("FAIL ovr_unr_set: got %h need %h", d, model_status());
    end
    w1c(32'hC);
    mmio_rd(OFF_STATUS, d);
    n_run++;
    if (d !== model_status() || d[3:2] !== 2'b00) begin
      n_fail++;
      $display("FAIL w1c: got %h need %h", d, model_status());
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] m;
    logic [7:0] mi, emi;
    logic [31:0] d, e;
    bit ok;
    int i0;
    m = 2'($urandom_range(0, 3));
    wr_ctrl(m);
    wr_data(8'($urandom), ok);
    cs_start(m[1]);
    spi_byte(m, 8'($urandom), 4, mi);
    @(negedge clk);
    resetn = 0;
    #1;
    n_run++;
    if ({miso, miso_oe, irq, mmio_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midrst_pins: got %b need 1000",
               {miso, miso_oe, irq, mmio_ready});
    end
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1;
    cs_end();
    mmio_rd(OFF_STATUS, d);
    n_run++;
    if (d !== model_status()) begin
      n_fail++;
      $display("FAIL midrst_status: got %h need %h", d, model_status());
    end
    wr_ctrl(m);
    wr_data(8'hC3, ok);
    i0 = irq_cnt;
    frame1(m, 8'hC3, mi, emi);
    n_run++;
    if (mi !== 8'hC3) begin
      n_fail++;
      $display("FAIL midrst_miso: got %h need c3", mi);
    end
    mmio_rd(OFF_DATA, d);
    e = {24'h0, m_rx_data}; m_rx_full = 0;
    n_run++;
    if (d !== e || d !== 32'hC3) begin
      n_fail++;
      $display("FAIL midrst_data: got %h need 000000c3", d);
    end
    n_run++;
    if (irq_cnt - i0 !== 1) begin
      n_fail++;
      $display("FAIL midrst_irq: got %0d need 1", irq_cnt - i0);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_burst();
    test_abort();
    test_tx_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
